// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 encodings,
// FSM state type and access-decoding helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    StIdle,
    StResp,
    StHold
  } lsu_state_e;

  // Byte-lane write mask; a word mask shifted by a non-zero lane is never used
  // because that access is flagged as misaligned.
  function automatic logic [3:0] byte_mask(input logic [2:0] funct3, input logic [1:0] lane);
    logic [3:0] base;
    case (funct3)
      F3_B, F3_BU: base = 4'b0001;
      F3_H, F3_HU: base = 4'b0011;
      F3_W:        base = 4'b1111;
      default:     base = 4'b0000;
    endcase
    return base << lane;
  endfunction

  function automatic logic access_exc(input logic [2:0] funct3, input logic [1:0] lane);
    logic exc;
    case (funct3)
      F3_B, F3_BU: exc = 1'b0;
      F3_H, F3_HU: exc = lane[0];
      F3_W:        exc = (lane != 2'b00);
      default:     exc = 1'b1;
    endcase
    return exc;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts the addressed byte/half/word from a raw SRAM word and sign- or
// zero-extends it to XLEN.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     raw_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      lane_i,
  output logic [XLEN-1:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (lane_i)
      2'd0:    byte_sel = raw_i[7:0];
      2'd1:    byte_sel = raw_i[15:8];
      2'd2:    byte_sel = raw_i[23:16];
      default: byte_sel = raw_i[31:24];
    endcase
    half_sel = lane_i[1] ? raw_i[31:16] : raw_i[15:0];
  end

  always_comb begin
    case (funct3_i)
      F3_B:    result_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_BU:   result_o = {{(XLEN-8){1'b0}}, byte_sel};
      F3_H:    result_o = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_HU:   result_o = {{(XLEN-16){1'b0}}, half_sel};
      F3_W:    result_o = XLEN'(raw_i);
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: drives the data SRAM in the accept cycle and
// returns aligned load data (or store/exception acks) one cycle later.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_req_valid,
  output logic              io_req_ready,
  input  logic              io_req_wen,
  input  logic [2:0]        io_req_funct3,
  input  logic [XLEN-1:0]   io_req_addr,
  input  logic [XLEN-1:0]   io_req_wdata,
  input  logic [4:0]        io_req_rd,
  output logic              io_resp_valid,
  input  logic              io_resp_ready,
  output logic [XLEN-1:0]   io_resp_data,
  output logic [4:0]        io_resp_rd,
  output logic              io_resp_is_load,
  output logic              io_resp_exc,
  output logic [3:0]        io_dm_w_en,
  output logic [ADDR_W-1:0] io_dm_address,
  output logic [31:0]       io_dm_write_data,
  input  logic [31:0]       io_dm_read_data
);

  lsu_state_e state_q, state_d;

  logic              fire;
  logic              use_hold;
  logic              req_exc;
  logic [1:0]        req_lane;
  logic [ADDR_W-1:0] req_dm_addr;
  logic [31:0]       req_dm_wdata;

  logic              wen_q;
  logic              exc_q;
  logic [2:0]        funct3_q;
  logic [1:0]        lane_q;
  logic [4:0]        rd_q;
  logic [ADDR_W-1:0] dm_addr_q;
  logic [31:0]       dm_wdata_q;
  logic [31:0]       hold_q;

  logic [31:0]       raw_word;
  logic [XLEN-1:0]   load_result;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^io_req_addr[XLEN-1:ADDR_W];

  assign req_lane    = io_req_addr[1:0];
  assign req_exc     = access_exc(io_req_funct3, req_lane);
  assign req_dm_addr = {io_req_addr[ADDR_W-1:2], 2'b00};
  // io_req_ready already folds in reset, so nothing fires while reset is low.
  assign fire        = io_req_valid && io_req_ready;

  always_comb begin
    case (io_req_funct3)
      F3_B, F3_BU: req_dm_wdata = {4{io_req_wdata[7:0]}};
      F3_H, F3_HU: req_dm_wdata = {2{io_req_wdata[15:0]}};
      default:     req_dm_wdata = io_req_wdata[31:0];
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (fire) state_d = StResp;
      StResp, StHold: begin
        if (io_resp_ready) begin
          state_d = fire ? StResp : StIdle;
        end else begin
          state_d = StHold;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    io_resp_valid = 1'b0;
    io_req_ready  = 1'b0;
    use_hold      = 1'b0;
    unique case (state_q)
      StIdle: io_req_ready = reset;
      StResp: begin
        io_resp_valid = reset;
        io_req_ready  = reset && io_resp_ready;
      end
      StHold: begin
        io_resp_valid = reset;
        io_req_ready  = reset && io_resp_ready;
        use_hold      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wen_q      <= 1'b0;
      exc_q      <= 1'b0;
      funct3_q   <= '0;
      lane_q     <= '0;
      rd_q       <= '0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      hold_q     <= '0;
    end else begin
      if (fire) begin
        wen_q      <= io_req_wen;
        exc_q      <= req_exc;
        funct3_q   <= io_req_funct3;
        lane_q     <= req_lane;
        rd_q       <= io_req_rd;
        dm_addr_q  <= req_dm_addr;
        dm_wdata_q <= req_dm_wdata;
      end
      // SRAM data is only valid for one cycle; keep it while the consumer stalls.
      if (state_q == StResp && !io_resp_ready) begin
        hold_q <= io_dm_read_data;
      end
    end
  end

  assign io_dm_address    = fire ? req_dm_addr : dm_addr_q;
  assign io_dm_write_data = fire ? req_dm_wdata : dm_wdata_q;
  assign io_dm_w_en       = (fire && io_req_wen && !req_exc) ?
                            byte_mask(io_req_funct3, req_lane) : 4'b0000;

  assign raw_word = use_hold ? hold_q : io_dm_read_data;

  lsu_load_align #(
    .XLEN(XLEN)
  ) u_load_align (
    .raw_i    (raw_word),
    .funct3_i (funct3_q),
    .lane_i   (lane_q),
    .result_o (load_result)
  );

  assign io_resp_data    = (io_resp_valid && !wen_q && !exc_q) ? load_result : '0;
  assign io_resp_rd      = io_resp_valid ? rd_q : 5'd0;
  assign io_resp_is_load = io_resp_valid && !wen_q;
  assign io_resp_exc     = io_resp_valid && exc_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu with a behavioural data SRAM and a
// response scoreboard.
module tb_mem_stage_lsu;
  import lsu_pkg::*;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned ADDR_W = 16;

  logic              clock = 1'b0;
  logic              reset;
  logic              io_req_valid, io_req_ready, io_req_wen;
  logic [2:0]        io_req_funct3;
  logic [XLEN-1:0]   io_req_addr, io_req_wdata;
  logic [4:0]        io_req_rd;
  logic              io_resp_valid, io_resp_ready;
  logic [XLEN-1:0]   io_resp_data;
  logic [4:0]        io_resp_rd;
  logic              io_resp_is_load, io_resp_exc;
  logic [3:0]        io_dm_w_en;
  logic [ADDR_W-1:0] io_dm_address;
  logic [31:0]       io_dm_write_data, io_dm_read_data;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        is_load;
    logic        exc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  logic [31:0] mem [0:16383];
  logic [31:0] sram_rdata;
  logic        corrupt;

  always #5 clock = ~clock;

  mem_stage_lsu #(
    .XLEN   (XLEN),
    .ADDR_W (ADDR_W)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .io_req_valid     (io_req_valid),
    .io_req_ready     (io_req_ready),
    .io_req_wen       (io_req_wen),
    .io_req_funct3    (io_req_funct3),
    .io_req_addr      (io_req_addr),
    .io_req_wdata     (io_req_wdata),
    .io_req_rd        (io_req_rd),
    .io_resp_valid    (io_resp_valid),
    .io_resp_ready    (io_resp_ready),
    .io_resp_data     (io_resp_data),
    .io_resp_rd       (io_resp_rd),
    .io_resp_is_load  (io_resp_is_load),
    .io_resp_exc      (io_resp_exc),
    .io_dm_w_en       (io_dm_w_en),
    .io_dm_address    (io_dm_address),
    .io_dm_write_data (io_dm_write_data),
    .io_dm_read_data  (io_dm_read_data)
  );

  // Synchronous SRAM, one-cycle read latency; corrupt overrides the read port.
  always @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (io_dm_w_en[i]) mem[io_dm_address[15:2]][8*i +: 8] <= io_dm_write_data[8*i +: 8];
    end
    sram_rdata <= mem[io_dm_address[15:2]];
  end
  assign io_dm_read_data = corrupt ? 32'h1234_5678 : sram_rdata;

  always @(negedge clock) begin
    if (io_resp_valid && io_resp_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL resp_unexpected got rd=%0d data=%h required none", io_resp_rd, io_resp_data);
      end else begin
        mon_e = exp_q.pop_front();
        if ({io_resp_rd, io_resp_data, io_resp_is_load, io_resp_exc} !== mon_e) begin
          failures++;
          $display("FAIL resp_scoreboard got rd=%0d data=%h load=%b exc=%b required rd=%0d data=%h load=%b exc=%b",
                   io_resp_rd, io_resp_data, io_resp_is_load, io_resp_exc,
                   mon_e.rd, mon_e.data, mon_e.is_load, mon_e.exc);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Drives a request, samples the fire cycle and records the expected response.
  task automatic issue(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd,
                       input logic [31:0] exp_data, input logic exp_exc);
    io_req_valid  = 1'b1;
    io_req_wen    = wen;
    io_req_funct3 = f3;
    io_req_addr   = addr;
    io_req_wdata  = wdata;
    io_req_rd     = rd;
    @(negedge clock);
    checks++;
    if (io_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL req_ready_fire rd=%0d got=%b required=1", rd, io_req_ready);
    end else begin
      exp_q.push_back('{rd: rd, data: exp_data, is_load: !wen, exc: exp_exc});
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; io_req_valid = 1'b1; io_req_wen = 1'b1; io_req_funct3 = F3_W;
    io_req_addr = 32'h40; io_req_wdata = 32'hFFFF_FFFF; io_req_rd = 5'd0;
    io_resp_ready = 1'b1; corrupt = 1'b0;
    repeat (3) tick;
    @(negedge clock);
    checks += 4;
    if (io_req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready got=%b required=0", io_req_ready); end
    if (io_resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b required=0", io_resp_valid); end
    if (io_dm_w_en !== 4'b0) begin failures++; $display("FAIL reset_w_en got=%b required=0000", io_dm_w_en); end
    if ({io_dm_address, io_dm_write_data, io_resp_data, io_resp_rd, io_resp_is_load, io_resp_exc} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got addr=%h wdata=%h data=%h rd=%0d required all 0",
               io_dm_address, io_dm_write_data, io_resp_data, io_resp_rd);
    end
    tick;
    reset = 1'b1; io_req_valid = 1'b0;
  endtask

  task automatic test_word;
    tick;
    issue(1'b1, F3_W, 32'h0000_0100, 32'hDEAD_BEEF, 5'd1, 32'h0, 1'b0);
    checks += 3;
    if (io_dm_w_en !== 4'b1111) begin failures++; $display("FAIL sw_w_en got=%b required=1111", io_dm_w_en); end
    if (io_dm_address !== 16'h0100) begin failures++; $display("FAIL sw_addr got=%h required=0100", io_dm_address); end
    if (io_dm_write_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL sw_wdata got=%h required=deadbeef", io_dm_write_data); end
    tick; io_req_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (io_resp_valid !== 1'b1) begin failures++; $display("FAIL sw_latency got=%b required=1", io_resp_valid); end
    tick;
    issue(1'b0, F3_W, 32'h0000_0100, 32'h0, 5'd2, 32'hDEAD_BEEF, 1'b0);
    checks++;
    if (io_dm_w_en !== 4'b0) begin failures++; $display("FAIL lw_w_en got=%b required=0000", io_dm_w_en); end
    tick; io_req_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (io_resp_valid !== 1'b1 || io_resp_data !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL lw_latency got valid=%b data=%h required valid=1 data=deadbeef", io_resp_valid, io_resp_data);
    end
  endtask

  task automatic test_stall;
    tick;
    io_resp_ready = 1'b0;
    issue(1'b0, F3_W, 32'h0000_0100, 32'h0, 5'd9, 32'hDEAD_BEEF, 1'b0);
    tick;
    // Next request waits on the stalled response.
    io_req_valid = 1'b1; io_req_wen = 1'b0; io_req_funct3 = F3_W;
    io_req_addr = 32'h0000_0100; io_req_rd = 5'd10;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) begin tick; corrupt = 1'b1; end
      @(negedge clock);
      checks += 2;
      if (io_resp_valid !== 1'b1 || io_resp_data !== 32'hDEAD_BEEF) begin
        failures++;
        $display("FAIL stall_data cycle=%0d got valid=%b data=%h required valid=1 data=deadbeef",
                 c, io_resp_valid, io_resp_data);
      end
      if (io_req_ready !== 1'b0) begin failures++; $display("FAIL stall_req_ready cycle=%0d got=%b required=0", c, io_req_ready); end
    end
    tick;
    io_resp_ready = 1'b1; corrupt = 1'b0;
    @(negedge clock);
    checks++;
    if (io_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_release_fire got=%b required=1", io_req_ready);
    end else begin
      exp_q.push_back('{rd: 5'd10, data: 32'hDEAD_BEEF, is_load: 1'b1, exc: 1'b0});
    end
    tick; io_req_valid = 1'b0;
    @(negedge clock);
    tick;
  endtask

  task automatic test_byte_and_back_to_back;
    logic [2:0]  f3s  [4] = '{F3_B, F3_BU, F3_H, F3_HU};
    logic [31:0] adrs [4] = '{32'h103, 32'h103, 32'h102, 32'h100};
    logic [31:0] exps [4] = '{32'hFFFF_FFA5, 32'h0000_00A5, 32'hFFFF_A5AD, 32'h0000_BEEF};
    issue(1'b1, F3_B, 32'h0000_0103, 32'h0000_00A5, 5'd3, 32'h0, 1'b0);
    checks += 2;
    if (io_dm_w_en !== 4'b1000) begin failures++; $display("FAIL sb_w_en got=%b required=1000", io_dm_w_en); end
    if (io_dm_write_data !== 32'hA5A5_A5A5) begin failures++; $display("FAIL sb_wdata got=%h required=a5a5a5a5", io_dm_write_data); end
    tick; io_req_valid = 1'b0;
    tick;
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, f3s[i], adrs[i], 32'h0, 5'(i + 1), exps[i], 1'b0);
      if (i > 0) begin
        checks++;
        if (io_resp_valid !== 1'b1 || io_resp_rd !== 5'(i)) begin
          failures++;
          $display("FAIL b2b_order i=%0d got valid=%b rd=%0d required valid=1 rd=%0d", i, io_resp_valid, io_resp_rd, i);
        end
      end
      tick;
    end
    io_req_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (io_resp_valid !== 1'b1 || io_resp_rd !== 5'd4) begin
      failures++;
      $display("FAIL b2b_last got valid=%b rd=%0d required valid=1 rd=4", io_resp_valid, io_resp_rd);
    end
    tick;
  endtask

  task automatic test_half;
    issue(1'b1, F3_H, 32'h0000_0102, 32'h0000_1234, 5'd13, 32'h0, 1'b0);
    checks += 2;
    if (io_dm_w_en !== 4'b1100) begin failures++; $display("FAIL sh_w_en got=%b required=1100", io_dm_w_en); end
    if (io_dm_write_data !== 32'h1234_1234) begin failures++; $display("FAIL sh_wdata got=%h required=12341234", io_dm_write_data); end
    tick; io_req_valid = 1'b0;
    tick;
    issue(1'b0, F3_W, 32'h0000_0100, 32'h0, 5'd14, 32'h1234_BEEF, 1'b0);
    tick; io_req_valid = 1'b0;
    tick;
  endtask

  task automatic test_exceptions;
    logic        wens [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f3s  [4] = '{F3_H, F3_W, 3'd3, 3'd6};
    logic [31:0] adrs [4] = '{32'h0011, 32'h0102, 32'h0100, 32'h0100};
    for (int i = 0; i < 4; i++) begin
      issue(wens[i], f3s[i], adrs[i], 32'hFFFF_FFFF, 5'(i + 5), 32'h0, 1'b1);
      checks++;
      if (io_dm_w_en !== 4'b0) begin failures++; $display("FAIL exc_w_en i=%0d got=%b required=0000", i, io_dm_w_en); end
      tick;
    end
    io_req_valid = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid;
    io_resp_ready = 1'b0;
    io_req_valid = 1'b1; io_req_wen = 1'b0; io_req_funct3 = F3_W;
    io_req_addr = 32'h0000_0100; io_req_rd = 5'd11;
    tick; io_req_valid = 1'b0;
    tick;
    reset = 1'b0;
    io_req_valid = 1'b1; io_req_wen = 1'b1; io_req_wdata = 32'hFFFF_FFFF; io_req_rd = 5'd12;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      checks++;
      if (io_resp_valid !== 1'b0 || io_req_ready !== 1'b0 || io_dm_w_en !== 4'b0) begin
        failures++;
        $display("FAIL mid_reset cycle=%0d got valid=%b ready=%b w_en=%b required 0 0 0000",
                 c, io_resp_valid, io_req_ready, io_dm_w_en);
      end
      tick;
    end
    reset = 1'b1; io_req_valid = 1'b0; io_resp_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (io_resp_valid !== 1'b0) begin failures++; $display("FAIL post_reset_idle got=%b required=0", io_resp_valid); end
    tick;
    issue(1'b0, F3_W, 32'h0000_0100, 32'h0, 5'd12, 32'h1234_BEEF, 1'b0);
    tick; io_req_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (io_resp_valid !== 1'b1) begin failures++; $display("FAIL post_reset_latency got=%b required=1", io_resp_valid); end
    tick; tick;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    test_reset;
    test_word;
    test_stall;
    test_byte_and_back_to_back;
    test_half;
    test_exceptions;
    test_reset_mid;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_responses got pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
